alu4_arbiter: RTL and testbench

- Shares the single gate-level 4-bit ALU datapath between two requesters using a round-robin policy.
- Accepts one operation per valid/ready handshake and drives registered, glitch-free operands into the ALU.
- Waits a fixed settle time for the ripple logic to resolve, then returns the result on a shared response channel tagged with the requester ID.
- Sits between the instruction/control side and the combinational ALU core.

---
 rtl/alu4_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 14 +
 rtl/alu4_arbiter.sv | 105 ++++++++++
 tb/tb_alu4_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared constants, FSM state encoding and ALU op codes for the 4-bit ALU arbiter slice.
package alu4_pkg;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned OP_WIDTH  = 3;
    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_ADD = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_AND = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 3'd4;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; ptr=0 favours requester 0 on contention.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant    = '0;
        grant[0] = valid[0] & (~valid[1] | ~ptr);
        grant[1] = valid[1] & (~valid[0] |  ptr);
    end

endmodule

// File: rtl/alu4_arbiter.sv
// Shares one combinational 4-bit ALU between two requesters: registers operands,
// waits SETTLE_CYCLES for the ripple logic, then returns the tagged result.
module alu4_arbiter
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH         = alu4_pkg::WIDTH,
    parameter int unsigned OP_WIDTH      = alu4_pkg::OP_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [OP_WIDTH-1:0] req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [OP_WIDTH-1:0] req1_op,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [OP_WIDTH-1:0] alu_op,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_cout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_cout
);

    state_t               state;
    logic                 ptr;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           grant;
    logic                 accept;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [OP_WIDTH-1:0]  sel_op;

    rr_arbiter2 u_rr (
        .valid ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        req0_ready = (state == IDLE) & grant[0];
        req1_ready = (state == IDLE) & grant[1];
        accept     = req0_ready | req1_ready;
        sel_a      = grant[1] ? req1_a  : req0_a;
        sel_b      = grant[1] ? req1_b  : req0_b;
        sel_op     = grant[1] ? req1_op : req0_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        rsp_id <= grant[1];
                        cnt    <= CNT_WIDTH'(SETTLE_CYCLES - 1);
                        // Next contention favours whoever was not granted now.
                        ptr    <= grant[0];
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_cout   <= alu_cout;
                        rsp_valid  <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed bench for alu4_arbiter: one instance with SETTLE_CYCLES=2, one with SETTLE_CYCLES=1,
// each driving a behavioural model of the combinational ALU.
module tb_alu4_arbiter;
    import alu4_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic [OP_WIDTH-1:0] req0_op, req1_op;
    logic [WIDTH-1:0]    alu_a, alu_b, alu_result;
    logic [OP_WIDTH-1:0] alu_op;
    logic                alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [WIDTH-1:0]    rsp_result;

    logic                s1_req0_valid, s1_req0_ready, s1_req1_valid, s1_req1_ready;
    logic [WIDTH-1:0]    s1_req0_a, s1_req0_b, s1_req1_a, s1_req1_b;
    logic [OP_WIDTH-1:0] s1_req0_op, s1_req1_op;
    logic [WIDTH-1:0]    s1_alu_a, s1_alu_b, s1_alu_result;
    logic [OP_WIDTH-1:0] s1_alu_op;
    logic                s1_alu_cout, s1_rsp_valid, s1_rsp_ready, s1_rsp_id, s1_rsp_cout;
    logic [WIDTH-1:0]    s1_rsp_result;

    int total = 0;
    int bad   = 0;
    int ng, nr;

    alu4_arbiter #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cout(rsp_cout)
    );

    alu4_arbiter #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready), .req0_a(s1_req0_a), .req0_b(s1_req0_b), .req0_op(s1_req0_op),
        .req1_valid(s1_req1_valid), .req1_ready(s1_req1_ready), .req1_a(s1_req1_a), .req1_b(s1_req1_b), .req1_op(s1_req1_op),
        .alu_a(s1_alu_a), .alu_b(s1_alu_b), .alu_op(s1_alu_op), .alu_result(s1_alu_result), .alu_cout(s1_alu_cout),
        .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready), .rsp_id(s1_rsp_id), .rsp_result(s1_rsp_result), .rsp_cout(s1_rsp_cout)
    );

    function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return '0;
        endcase
    endfunction

    always_comb {alu_cout, alu_result}       = alu_f(alu_a, alu_b, alu_op);
    always_comb {s1_alu_cout, s1_alu_result} = alu_f(s1_alu_a, s1_alu_b, s1_alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rsp_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        s1_req0_valid = 0; s1_req1_valid = 0; s1_rsp_ready = 0;
        s1_req0_a = '0; s1_req0_b = '0; s1_req0_op = '0; s1_req1_a = '0; s1_req1_b = '0; s1_req1_op = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_alu_a", alu_a, 0);        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);      chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);      chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_cout", rsp_cout, 0);  chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);  chk("rst1_rsp_valid", s1_rsp_valid, 0);

        // single request: 3 + 5
        @(negedge clk);
        req0_valid = 1; req0_a = 4'h3; req0_b = 4'h5; req0_op = OP_ADD;
        #1 chk("t1_ready0", req0_ready, 1); chk("t1_ready1", req1_ready, 0);
        @(negedge clk); req0_valid = 0;
        #1 chk("t1_rv_e0", rsp_valid, 0); chk("t1_alu_a", alu_a, 4'h3); chk("t1_alu_b", alu_b, 4'h5);
        chk("t1_ready_settle", req0_ready, 0);
        @(negedge clk); #1 chk("t1_rv_e1", rsp_valid, 0);
        @(negedge clk); #1 chk("t1_rv_e2", rsp_valid, 1);
        chk("t1_id", rsp_id, 0); chk("t1_res", rsp_result, 4'h8); chk("t1_cout", rsp_cout, 0);
        rsp_ready = 1;
        @(negedge clk); #1 chk("t1_rv_done", rsp_valid, 0); chk("t1_alu_a_hold", alu_a, 4'h3);

        // reset pulse so the pointer starts at 0 for contention
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;

        // contention: grants must alternate 0,1,0,1
        req0_a = 4'h1; req0_b = 4'h2; req0_op = OP_ADD;
        req1_a = 4'h6; req1_b = 4'h7; req1_op = OP_ADD;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        ng = 0; nr = 0;
        for (int i = 0; i < 40 && nr < 4; i++) begin
            #1;
            chk("t2_onehot", req0_ready & req1_ready, 0);
            if (req0_ready | req1_ready) begin
                chk("t2_grant", req1_ready, ng % 2);
                ng++;
            end
            if (rsp_valid) begin
                chk("t2_id", rsp_id, nr % 2);
                chk("t2_res", rsp_result, (nr % 2) ? 4'hD : 4'h3);
                nr++;
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        chk("t2_nrsp", nr, 4); chk("t2_ngrant", ng, 4);

        // backpressure: F + 1 wraps to 0 with carry
        @(negedge clk);
        rsp_ready = 0; req0_a = 4'hF; req0_b = 4'h1; req0_op = OP_ADD; req0_valid = 1;
        #1 chk("t3_ready0", req0_ready, 1);
        @(negedge clk); req0_valid = 0;
        wait_rsp("t3_wait", 6);
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_rv", rsp_valid, 1);     chk("t3_res", rsp_result, 4'h0);
            chk("t3_cout", rsp_cout, 1);    chk("t3_id", rsp_id, 0);
            chk("t3_ready0", req0_ready, 0); chk("t3_ready1", req1_ready, 0);
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        @(negedge clk);
        #1 chk("t3_rv_clear", rsp_valid, 0);
        req0_valid = 1;
        #1 chk("t3_idle_ready", req0_ready, 1);
        req0_valid = 0;

        // reset mid-op: req0 in flight leaves pointer at 1 unless reset clears it
        @(negedge clk);
        rsp_ready = 0; req0_a = 4'h2; req0_b = 4'h2; req0_op = OP_XOR; req0_valid = 1;
        @(negedge clk); req0_valid = 0;
        #1 chk("t4_alu_op_pre", alu_op, OP_XOR);
        rst = 1;
        #1 chk("t4_rv", rsp_valid, 0); chk("t4_alu_a", alu_a, 0); chk("t4_alu_b", alu_b, 0);
        chk("t4_alu_op", alu_op, 0);
        @(negedge clk); rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t4_no_rsp", rsp_valid, 0);
            @(negedge clk);
        end
        req0_a = 4'h2; req0_b = 4'h2; req0_op = OP_ADD;
        req1_a = 4'h9; req1_b = 4'h9; req1_op = OP_ADD;
        req0_valid = 1; req1_valid = 1;
        #1 chk("t4_ready0", req0_ready, 1); chk("t4_ready1", req1_ready, 0);
        @(negedge clk); req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        wait_rsp("t4_wait", 6);
        chk("t4_id", rsp_id, 0); chk("t4_res", rsp_result, 4'h4); chk("t4_cout", rsp_cout, 0);
        @(negedge clk);

        // withdrawn request during RESPOND must not grant or move the pointer
        rsp_ready = 0; req0_a = 4'hC; req0_b = 4'hA; req0_op = OP_AND; req0_valid = 1;
        @(negedge clk); req0_valid = 0;
        wait_rsp("t5_wait", 6);
        req1_valid = 1;
        #1 chk("t5_ready1_respond", req1_ready, 0);
        @(negedge clk); req1_valid = 0;
        #1 chk("t5_rv_hold", rsp_valid, 1); chk("t5_res", rsp_result, 4'h8);
        rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        req0_a = 4'h1; req0_b = 4'h1; req0_op = OP_ADD;
        req1_a = 4'h5; req1_b = 4'h3; req1_op = OP_SUB;
        req0_valid = 1; req1_valid = 1;
        #1 chk("t5_ptr_ready1", req1_ready, 1); chk("t5_ptr_ready0", req0_ready, 0);
        @(negedge clk); req0_valid = 0; req1_valid = 0;
        wait_rsp("t5_wait2", 6);
        chk("t5_id1", rsp_id, 1); chk("t5_res1", rsp_result, 4'h2); chk("t5_cout1", rsp_cout, 0);
        @(negedge clk);
        req0_a = 4'h6; req0_b = 4'h3; req0_op = OP_OR; req0_valid = 1;
        #1 chk("t5_ready0", req0_ready, 1);
        @(negedge clk); req0_valid = 0;
        wait_rsp("t5_wait3", 6);
        chk("t5_id0", rsp_id, 0); chk("t5_res0", rsp_result, 4'h7);
        @(negedge clk);

        // SETTLE_CYCLES=1: accept every 3 cycles, response 1 edge after accept
        s1_req0_a = 4'h7; s1_req0_b = 4'h8; s1_req0_op = OP_ADD;
        s1_req0_valid = 1; s1_rsp_ready = 1;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t6_ready", s1_req0_ready, (i % 3 == 0));
            chk("t6_rsp", s1_rsp_valid, (i % 3 == 2));
            if (i % 3 == 2) chk("t6_res", s1_rsp_result, 4'hF);
            @(negedge clk);
        end
        s1_req0_valid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
